// File: rtl/st5_writeback_stage_pkg.sv
// Shared datapath definitions for the 16-bit MIPS pipeline: MemRead encodings,
// default widths and the write-back entry record.
package st5_writeback_stage_pkg;

  localparam int unsigned DefaultDw = 16;
  localparam int unsigned DefaultRw = 4;
  localparam int unsigned RetireCntW = 16;

  localparam logic [1:0] MR_NONE = 2'b00;
  localparam logic [1:0] MR_LW   = 2'b01;
  localparam logic [1:0] MR_LBU  = 2'b10;
  localparam logic [1:0] MR_RSVD = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [DefaultRw-1:0] wreg;
    logic [DefaultDw-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/st5_writeback_stage_wb_data_select.sv
// Write-back data mux: picks ALU result, loaded word or zero-extended loaded byte.
module st5_writeback_stage_wb_data_select
  import st5_writeback_stage_pkg::*;
#(
  parameter int unsigned DW = DefaultDw
) (
  input  logic [1:0]    memread_i,
  input  logic [DW-1:0] alu_result_i,
  input  logic [DW-1:0] read_data_i,
  output logic [DW-1:0] data_o,
  output logic          bad_o
);

  always_comb begin
    data_o = alu_result_i;
    bad_o  = 1'b0;
    unique case (memread_i)
      MR_LW:   data_o = read_data_i;
      MR_LBU:  data_o = {{(DW-8){1'b0}}, read_data_i[7:0]};
      MR_NONE: data_o = alu_result_i;
      MR_RSVD: begin
        data_o = alu_result_i;
        bad_o  = 1'b1;
      end
      default: data_o = alu_result_i;
    endcase
  end

endmodule

// File: rtl/st5_writeback_stage.sv
// Pipeline stage 5: MEM/WB register, register-file write port, one-deep
// forwarding history and retire counter.
module st5_writeback_stage
  import st5_writeback_stage_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned RW = DefaultRw
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  input  logic [1:0]            mem_memread_i,
  input  logic                  mem_regwrite_i,
  input  logic [RW-1:0]         mem_writereg_i,
  input  logic [DW-1:0]         mem_aluresult_i,
  input  logic [DW-1:0]         mem_readdata_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  wb_regwrite_o,
  output logic [RW-1:0]         wb_writereg_o,
  output logic [DW-1:0]         wb_writedata_o,
  output logic                  fwd_hit_valid_o,
  output logic [RW-1:0]         fwd_hit_reg_o,
  output logic [DW-1:0]         fwd_hit_data_o,
  output logic                  bad_memread_o,
  output logic [RetireCntW-1:0] retire_count_o
);

  wb_entry_t             mw_q, mw_d;
  wb_entry_t             hist_q, hist_d;
  logic                  bad_q, bad_d;
  logic [RetireCntW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] sel_data;
  logic          sel_bad;

  st5_writeback_stage_wb_data_select #(
    .DW (DW)
  ) u_data_select (
    .memread_i    (mem_memread_i),
    .alu_result_i (mem_aluresult_i),
    .read_data_i  (mem_readdata_i),
    .data_o       (sel_data),
    .bad_o        (sel_bad)
  );

  always_comb begin
    mw_d  = mw_q;
    bad_d = bad_q;
    if (flush_i) begin
      mw_d.valid = 1'b0;
    end else if (!stall_i) begin
      mw_d.valid    = mem_valid_i;
      mw_d.regwrite = mem_regwrite_i;
      mw_d.wreg     = mem_writereg_i;
      mw_d.data     = sel_data;
      bad_d         = sel_bad;
    end
  end

  // History tracks the entry leaving the stage; flush alone does not clear it.
  always_comb begin
    hist_d = hist_q;
    if (!stall_i) begin
      hist_d.valid    = wb_regwrite_o;
      hist_d.regwrite = wb_regwrite_o;
      hist_d.wreg     = mw_q.wreg;
      hist_d.data     = mw_q.data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mw_q.valid && !stall_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mw_q   <= '0;
      hist_q <= '0;
      bad_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mw_q   <= mw_d;
      hist_q <= hist_d;
      bad_q  <= bad_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wb_regwrite_o   = mw_q.valid & mw_q.regwrite & (mw_q.wreg != '0);
  assign wb_writereg_o   = mw_q.wreg;
  assign wb_writedata_o  = mw_q.data;
  assign fwd_hit_valid_o = hist_q.valid;
  assign fwd_hit_reg_o   = hist_q.wreg;
  assign fwd_hit_data_o  = hist_q.data;
  assign bad_memread_o   = mw_q.valid & bad_q;
  assign retire_count_o  = cnt_q;

endmodule
